div_scheduler: RTL and testbench

- Time-multiplexes one pipelined remainder divider (the `div` IP, registered on `clock`) among NUM_REQ requesters.
- Requesters are horizon-side random-number reducers: cloud level, cloud gap, obstacle gap and star placement.
- Fair round-robin arbitration; a tag pipeline that follows the divider latency and routes each remainder back to its requester.
- Flush on crash; zero-denominator protection.
- Sits between the horizon controller logic and a single `div` instance.

---
 rtl/div_scheduler_if.sv | 25 ++
 rtl/div_scheduler.sv | 138 +++++++++++++
 tb/tb_div_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_scheduler_if.sv
// Requester-side bundle of the divider scheduler: requests and operands in,
// grants, done pulses and the shared remainder out.
interface div_scheduler_if #(
  parameter int NUM_REQ     = 4,
  parameter int NUMER_WIDTH = 11,
  parameter int DENOM_WIDTH = 11
);
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ-1:0][NUMER_WIDTH-1:0] numer;
  logic [NUM_REQ-1:0][DENOM_WIDTH-1:0] denom;
  logic [NUM_REQ-1:0]                  grant;
  logic [NUM_REQ-1:0]                  done;
  logic [DENOM_WIDTH-1:0]              remain;
  logic                                busy;

  modport master (
    output req, numer, denom,
    input  grant, done, remain, busy
  );

  modport slave (
    input  req, numer, denom,
    output grant, done, remain, busy
  );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin time-multiplexer for one pipelined remainder divider; a tag
// pipeline tracks each operation so its remainder returns to the issuer.
module div_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int NUMER_WIDTH = 11,
  parameter int DENOM_WIDTH = 11,
  parameter int DIV_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  div_scheduler_if.slave         rq,
  output logic [NUMER_WIDTH-1:0] div_numer,
  output logic [DENOM_WIDTH-1:0] div_denom,
  input  logic [DENOM_WIDTH-1:0] div_remain
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Stage 0 is aligned with the operand registers, the last stage with div_remain.
  localparam int STAGES = DIV_LATENCY + 1;

  typedef struct packed {
    logic            valid;
    logic            zero;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]        ptr_r;
  logic [ID_W-1:0]        ptr_next;
  tag_t                   tag_r    [STAGES];
  tag_t                   tag_next [STAGES];
  logic [NUM_REQ-1:0]     grant_s;
  logic [ID_W-1:0]        gidx_s;
  logic                   found_s;
  logic                   transfer_s;
  logic                   zero_s;
  logic [NUM_REQ-1:0]     done_r;
  logic [NUM_REQ-1:0]     done_next;
  logic [DENOM_WIDTH-1:0] remain_r;
  logic [DENOM_WIDTH-1:0] remain_next;
  logic                   busy_r;
  logic                   busy_next;
  logic [NUMER_WIDTH-1:0] numer_r;
  logic [DENOM_WIDTH-1:0] denom_r;

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    if (!rst && !flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && rq.req[(int'(ptr_r) + i) % NUM_REQ]) begin
          found_s = 1'b1;
          gidx_s  = ID_W'((int'(ptr_r) + i) % NUM_REQ);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
    if (found_s) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign transfer_s = |(rq.req & grant_s);
  assign zero_s     = (rq.denom[gidx_s] == {DENOM_WIDTH{1'b0}});
  assign ptr_next   = (int'(gidx_s) == NUM_REQ - 1) ? ID_W'(0) : gidx_s + ID_W'(1);

  // Tag shift, result capture and busy look-ahead.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      tag_next[s] = '0;
    end
    done_next   = '0;
    remain_next = remain_r;
    busy_next   = 1'b0;
    if (flush) begin
      done_next = '0;
    end else begin
      tag_next[0].valid = transfer_s;
      tag_next[0].zero  = transfer_s & zero_s;
      tag_next[0].id    = gidx_s;
      for (int s = 1; s < STAGES; s++) begin
        tag_next[s] = tag_r[s-1];
      end
      if (tag_r[STAGES-1].valid) begin
        done_next[tag_r[STAGES-1].id] = 1'b1;
        remain_next = tag_r[STAGES-1].zero ? {DENOM_WIDTH{1'b0}} : div_remain;
      end else begin
        done_next = '0;
      end
    end
    for (int s = 0; s < STAGES; s++) begin
      busy_next = busy_next | tag_next[s].valid;
    end
    busy_next = busy_next | (|done_next);
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_r[s] <= '0;
      end
      done_r   <= '0;
      remain_r <= '0;
      busy_r   <= 1'b0;
      numer_r  <= '0;
      denom_r  <= DENOM_WIDTH'(1);
    end else begin
      if (transfer_s) begin
        ptr_r   <= ptr_next;
        numer_r <= rq.numer[gidx_s];
        denom_r <= zero_s ? DENOM_WIDTH'(1) : rq.denom[gidx_s];
      end
      for (int s = 0; s < STAGES; s++) begin
        tag_r[s] <= tag_next[s];
      end
      done_r   <= done_next;
      remain_r <= remain_next;
      busy_r   <= busy_next;
    end
  end

  assign rq.grant  = grant_s;
  assign rq.done   = done_r;
  assign rq.remain = remain_r;
  assign rq.busy   = busy_r;
  assign div_numer = numer_r;
  assign div_denom = denom_r;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: transaction-level model (issue queue with due
// cycles) checked every cycle, directed scenarios and randomized traffic.
module tb_div_scheduler;
  localparam int NR  = 4;
  localparam int NW  = 11;
  localparam int DW  = 11;
  localparam int LAT = 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          flush = 1'b0;
  logic [NW-1:0] div_numer;
  logic [DW-1:0] div_denom;
  logic [DW-1:0] div_remain;
  logic [DW-1:0] dpipe [LAT];

  div_scheduler_if #(.NUM_REQ(NR), .NUMER_WIDTH(NW), .DENOM_WIDTH(DW)) bus ();

  div_scheduler #(
    .NUM_REQ(NR), .NUMER_WIDTH(NW), .DENOM_WIDTH(DW), .DIV_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .rq(bus),
    .div_numer(div_numer),
    .div_denom(div_denom),
    .div_remain(div_remain)
  );

  always #5 clk = ~clk;

  // Pipelined divider stand-in.
  always @(posedge clk) begin
    dpipe[0] <= (div_denom == '0) ? '0 : (div_numer % div_denom);
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_remain = dpipe[LAT-1];

  typedef struct {
    int            id;
    int            due;
    logic [DW-1:0] rem;
  } op_t;

  op_t           q[$];
  int            cyc   = 0;
  int            ptr_m = 0;
  int            total = 0;
  int            bad   = 0;
  logic [NW-1:0] ops_n = '0;
  logic [DW-1:0] ops_d = 11'd1;
  bit            rem_clear = 1'b1;

  logic [NR-1:0] seen_grant, seen_done;
  logic [DW-1:0] seen_remain, seen_div_denom;
  logic [NW-1:0] seen_div_numer;
  logic          seen_busy;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Compare the DUT with the transaction model for the current cycle, then advance the model.
  task automatic model_step();
    logic [NR-1:0] eg, ed;
    logic [DW-1:0] er;
    int            gid;
    op_t           op;
    eg = '0; ed = '0; er = '0; gid = -1;
    if (!rst && !flush)
      for (int i = 0; i < NR; i++)
        if (gid < 0 && bus.req[(ptr_m + i) % NR]) gid = (ptr_m + i) % NR;
    if (gid >= 0) eg[gid] = 1'b1;
    if (q.size() > 0 && q[0].due == cyc) begin
      ed[q[0].id] = 1'b1;
      er = q[0].rem;
    end
    check("grant", 64'(bus.grant), 64'(eg));
    check("done", 64'(bus.done), 64'(ed));
    check("busy", 64'(bus.busy), 64'(q.size() > 0));
    check("div_numer", 64'(div_numer), 64'(ops_n));
    check("div_denom", 64'(div_denom), 64'(ops_d));
    if (ed != '0) check("remain", 64'(bus.remain), 64'(er));
    else if (rem_clear) check("remain_reset", 64'(bus.remain), 64'd0);
    seen_grant = bus.grant; seen_done = bus.done; seen_remain = bus.remain;
    seen_busy = bus.busy; seen_div_numer = div_numer; seen_div_denom = div_denom;
    if (ed != '0) begin
      void'(q.pop_front());
      rem_clear = 1'b0;
    end
    if (rst) begin
      q.delete(); ptr_m = 0; ops_n = '0; ops_d = 11'd1; rem_clear = 1'b1;
    end else if (flush) begin
      q.delete();
    end else if (gid >= 0) begin
      op.id  = gid;
      op.due = cyc + 2 + LAT;
      op.rem = (bus.denom[gid] == '0) ? '0 : DW'(bus.numer[gid] % bus.denom[gid]);
      q.push_back(op);
      ptr_m = (gid + 1) % NR;
      ops_n = bus.numer[gid];
      ops_d = (bus.denom[gid] == '0) ? 11'd1 : bus.denom[gid];
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input int n, input int d);
    bus.req[k]   = 1'b1;
    bus.numer[k] = NW'(n);
    bus.denom[k] = DW'(d);
  endtask

  task automatic idle(input int n);
    bus.req = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [DW-1:0] exp4 [4];
  bit            got3;

  initial begin
    bus.req = '0; bus.numer = '0; bus.denom = '0;
    exp4[0] = 11'd6; exp4[1] = 11'd127; exp4[2] = 11'd4; exp4[3] = 11'd0;
    @(posedge clk); #1;
    tick(); tick();
    check("lit_reset_denom", 64'(seen_div_denom), 64'd1);
    check("lit_reset_busy", 64'(seen_busy), 64'd0);
    rst = 1'b0;

    // Single request, pointer 0.
    set_op(0, 1000, 7);
    tick();
    check("lit_single_grant", 64'(seen_grant), 64'h1);
    bus.req = '0;
    tick();
    check("lit_single_busy", 64'(seen_busy), 64'd1);
    tick(); tick();
    check("lit_single_done", 64'(seen_done), 64'h1);
    check("lit_single_remain", 64'(seen_remain), 64'd6);
    idle(2);

    // All four at once from pointer 0.
    do_reset();
    set_op(0, 1000, 7); set_op(1, 2047, 640); set_op(2, 500, 31); set_op(3, 37, 37);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 4) check("lit_all_grant", 64'(seen_grant), 64'(1 << i));
      if (i >= 3) begin
        check("lit_all_done", 64'(seen_done), 64'(1 << (i - 3)));
        check("lit_all_remain", 64'(seen_remain), 64'(exp4[i-3]));
      end
      bus.req = bus.req & ~seen_grant;
    end
    idle(2);

    // Fairness: move pointer to 2, then req=0011, then 0 hammering vs 3.
    do_reset();
    set_op(1, 5, 3);
    tick();
    check("lit_fair_setup", 64'(seen_grant), 64'h2);
    set_op(0, 9, 4); set_op(1, 10, 4);
    tick();
    check("lit_fair_first", 64'(seen_grant), 64'h1);
    bus.req[0] = 1'b0;
    tick();
    check("lit_fair_second", 64'(seen_grant), 64'h2);
    bus.req = '0;
    set_op(0, 77, 5); set_op(3, 88, 6);
    got3 = 1'b0;
    for (int i = 0; i < 4 && !got3; i++) begin
      tick();
      if (seen_grant[3]) begin
        got3 = 1'b1;
        bus.req[3] = 1'b0;
      end
    end
    check("lit_fair_req3", 64'(got3), 64'd1);
    idle(5);

    // Zero denominator.
    set_op(2, 500, 0);
    tick();
    check("lit_zero_grant", 64'(seen_grant), 64'h4);
    bus.req = '0;
    tick();
    check("lit_zero_div_denom", 64'(seen_div_denom), 64'd1);
    check("lit_zero_div_numer", 64'(seen_div_numer), 64'd500);
    tick(); tick();
    check("lit_zero_done", 64'(seen_done), 64'h4);
    check("lit_zero_remain", 64'(seen_remain), 64'd0);
    idle(3);

    // Flush one cycle after the second transfer.
    set_op(0, 1234, 100);
    tick();
    bus.req[0] = 1'b0;
    set_op(1, 99, 10);
    tick();
    bus.req[1] = 1'b0;
    set_op(2, 100, 9);
    flush = 1'b1;
    tick();
    check("lit_flush_grant", 64'(seen_grant), 64'h0);
    flush = 1'b0;
    tick();
    check("lit_flush_regrant", 64'(seen_grant), 64'h4);
    check("lit_flush_nodone", 64'(seen_done), 64'h0);
    check("lit_flush_busy", 64'(seen_busy), 64'd0);
    bus.req = '0;
    tick();
    check("lit_flush_busy2", 64'(seen_busy), 64'd1);
    tick(); tick();
    check("lit_flush_done", 64'(seen_done), 64'h4);
    check("lit_flush_remain", 64'(seen_remain), 64'd1);
    idle(2);

    // Reset one cycle after a transfer.
    set_op(2, 50, 7);
    tick();
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(1, 300, 11); set_op(3, 77, 0);
    tick();
    check("lit_rst_grant", 64'(seen_grant), 64'h2);
    check("lit_rst_busy", 64'(seen_busy), 64'd0);
    check("lit_rst_done", 64'(seen_done), 64'h0);
    check("lit_rst_div_denom", 64'(seen_div_denom), 64'd1);
    bus.req[1] = 1'b0;
    tick();
    check("lit_rst_grant2", 64'(seen_grant), 64'h8);
    idle(6);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
      for (int k = 0; k < NR; k++) begin
        if (bus.req[k] && seen_grant[k]) begin
          if ($urandom_range(0, 1) == 0)
            set_op(k, int'($urandom_range(0, 2047)),
                   ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2047)));
          else
            bus.req[k] = 1'b0;
        end else if (!bus.req[k] && $urandom_range(0, 9) < 3) begin
          set_op(k, int'($urandom_range(0, 2047)),
                 ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2047)));
        end
      end
    end
    flush = 1'b0;
    rst   = 1'b0;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
